dac_sample_buffer: RTL and testbench
====================================

Name: dac_sample_buffer

Overview:
- Output stage between the FIR filter and the I2S controller's DAC path.
- Takes one-cycle `done` pulses with filtered samples from the FIR.
- Applies a configurable saturating left-shift gain, then queues samples in a small FIFO.
- Hands samples to the I2S controller on its per-frame request pulse, so FIR completion timing is decoupled from the serializer frame timing. Overflow and underflow are reported as sticky flags.

Parameters:
- DataWidth, 12, sample width (signed two's complement).
- Depth, 4, FIFO entries; power of two, minimum 2.
- GainWidth, 2, width of the gain shift control (shift range 0..2^GainWidth-1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- inData  input  DataWidth  signed sample from the FIR.
- inValid  input  1  one-cycle pulse; inData is valid this cycle.
- gainShift  input  GainWidth  left-shift amount applied on write; quasi-static.
- holdOnEmpty  input  1  underflow policy: 1 = repeat the last delivered sample, 0 = output zero.
- outReq  input  1  one-cycle request from the I2S controller for the next sample.
- outData  output  DataWidth  registered sample to the DAC serializer.
- outValid  output  1  one-cycle pulse, exactly 1 cycle after outReq.
- level  output  $clog2(Depth+1)  current FIFO occupancy.
- overflow  output  1  sticky: a write was dropped.
- underflow  output  1  sticky: a request found the FIFO empty.
- clearFlags  input  1  clears the overflow and underflow flags.

Behaviour:
- Reset (async, applied immediately): FIFO pointers and level = 0; outData = 0; outValid = 0; overflow = 0; underflow = 0; last-delivered register = 0. Reset mid-operation discards all queued samples.
- Gain, applied combinationally before storage:
  - Compute the full-precision value inData << gainShift.
  - If the result is greater than 2^(DataWidth-1)-1, store that maximum; if less than -2^(DataWidth-1), store that minimum.
  - gainShift = 0 passes the sample through unchanged.
  - gainShift is sampled on the cycle of inValid.
- Write, on inValid:
  - If level < Depth: store at the write pointer, increment the write pointer (wraps modulo Depth), level+1.
  - If level == Depth: drop the sample, set overflow; FIFO contents unchanged.
- Read, on outReq:
  - If level > 0: next cycle outData = head entry, outValid = 1; the read pointer increments (wraps), level-1, and the last-delivered register takes the head value.
  - If level == 0: next cycle outData = last-delivered (holdOnEmpty = 1) or 0 (holdOnEmpty = 0), outValid = 1, and underflow is set. The last-delivered register is unchanged.
- Simultaneous events:
  - inValid and outReq with the FIFO full: the pop and the push both occur, level stays Depth, no overflow.
  - inValid and outReq with the FIFO empty: there is no bypass. The request underflows and the new sample is enqueued, so level becomes 1.
  - clearFlags in the same cycle as a new overflow or underflow event: set wins, and the flag reads 1 the next cycle.
- outValid is high for exactly one cycle per outReq. When outValid is low, outData holds its previous value.
- Back-to-back outReq pulses on consecutive cycles are each serviced in order.
- level is registered and updates the cycle after a push or pop.

Test Plan:
- Gain and saturation:
  - gainShift = 0, push 0x123 -> delivered 0x123.
  - gainShift = 2, push 0x100 -> 0x400.
  - gainShift = 2, push 0x300 -> 0x7FF.
  - gainShift = 1, push 0x900 (-1792) -> 0x800.
- Ordering and latency: push 1, 2, 3, 4, then four outReq pulses -> outValid exactly 1 cycle after each request, data 1, 2, 3, 4; level steps 4→0.
- Overflow: push five samples (10..14) with no reads -> overflow = 1, level = 4, reads return 10..13. Then clearFlags -> overflow = 0.
- Underflow policy:
  - Deliver 0x055, then request with the FIFO empty and holdOnEmpty = 1 -> 0x055, underflow = 1.
  - Repeat with holdOnEmpty = 0 -> 0x000.
- Simultaneous events:
  - FIFO full (level = 4), inValid and outReq together -> oldest sample delivered, new sample queued, level stays 4, overflow stays 0.
  - FIFO empty, inValid and outReq together -> underflow = 1, level = 1.
- Reset mid-stream: level = 3, assert reset for 1 cycle -> level = 0, outData = 0, flags = 0; the next outReq with holdOnEmpty = 1 returns 0.

Source files
------------

// File: rtl/dac_sample_buffer_if.sv
// Sample bus between the FIR output, the DAC sample buffer and the I2S request side.
// The slave modport is the buffer's view. The master modport is the view of whoever drives
// the FIR samples and the I2S requests.
interface dac_sample_buffer_if #(
  parameter int DataWidth = 12,
  parameter int Depth     = 4,
  parameter int GainWidth = 2
);
  localparam int LevelWidth = $clog2(Depth + 1);

  logic [DataWidth-1:0]  inData;
  logic                  inValid;
  logic [GainWidth-1:0]  gainShift;
  logic                  holdOnEmpty;
  logic                  outReq;
  logic                  clearFlags;
  logic [DataWidth-1:0]  outData;
  logic                  outValid;
  logic [LevelWidth-1:0] level;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  inData, inValid, gainShift, holdOnEmpty, outReq, clearFlags,
    output outData, outValid, level, overflow, underflow
  );

  modport master (
    output inData, inValid, gainShift, holdOnEmpty, outReq, clearFlags,
    input  outData, outValid, level, overflow, underflow
  );
endinterface

// File: rtl/dac_sample_buffer.sv
// DAC sample buffer.
// It applies a saturating left-shift gain to each FIR sample and queues the result in a small FIFO.
// It delivers one registered sample per I2S request. Sticky overflow and underflow flags are kept.
module dac_sample_buffer #(
  parameter int DataWidth = 12,
  parameter int Depth     = 4,
  parameter int GainWidth = 2
) (
  input  logic clk,
  input  logic reset,
  dac_sample_buffer_if.slave bus
);
  localparam int AddrWidth  = $clog2(Depth);
  localparam int LevelWidth = $clog2(Depth + 1);
  // Largest shift the gain control can request; the intermediate value is widened by this many bits
  localparam int MaxShift   = (1 << GainWidth) - 1;
  localparam int FullWidth  = DataWidth + MaxShift;

  localparam logic [DataWidth-1:0] SatMax = {1'b0, {(DataWidth-1){1'b1}}};
  localparam logic [DataWidth-1:0] SatMin = {1'b1, {(DataWidth-1){1'b0}}};

  // Sample storage, no reset so it maps onto plain RAM
  logic [DataWidth-1:0] mem [Depth];

  logic [AddrWidth-1:0]  wr_ptr_reg;
  logic [AddrWidth-1:0]  rd_ptr_reg;
  logic [LevelWidth-1:0] level_reg;
  logic [DataWidth-1:0]  out_data_reg;
  logic                  out_valid_reg;
  logic [DataWidth-1:0]  last_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic [FullWidth-1:0]  extended;
  logic [FullWidth-1:0]  shifted;
  logic [MaxShift:0]     upper;
  logic [DataWidth-1:0]  gained;

  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;
  logic                  overflow_event;
  logic                  underflow_event;
  logic [LevelWidth-1:0] level_next;

  // Gain: sign-extend the sample, shift it at full precision, then clamp it to the sample range.
  // The shifted value fits only when every bit from the sample sign position upward is the same.
  always_comb begin
    extended = {{MaxShift{bus.inData[DataWidth-1]}}, bus.inData};
    shifted  = extended << bus.gainShift;
    upper    = shifted[FullWidth-1:DataWidth-1];
    gained   = shifted[DataWidth-1:0];
    if (!((upper == '0) || (upper == '1))) begin
      gained = shifted[FullWidth-1] ? SatMin : SatMax;
    end
  end

  // Push and pop decisions.
  // A full FIFO still accepts a write when a read pops in the same cycle.
  // An empty FIFO never bypasses the new sample straight to the output.
  always_comb begin
    empty           = (level_reg == '0);
    full            = (level_reg == LevelWidth'(Depth));
    do_pop          = bus.outReq && !empty;
    do_push         = bus.inValid && (!full || bus.outReq);
    overflow_event  = bus.inValid && full && !bus.outReq;
    underflow_event = bus.outReq && empty;
    level_next      = level_reg + LevelWidth'(do_push) - LevelWidth'(do_pop);
  end

  // Store the gained sample at the write pointer
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= gained;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AddrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AddrWidth'(1);
      end
      level_reg <= level_next;
    end
  end

  // Output register and last-delivered sample.
  // On a full push and pop to the same slot, the read sees the old entry.
  // On underflow the output is either the held sample or zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      last_reg      <= '0;
    end else begin
      out_valid_reg <= bus.outReq;
      if (do_pop) begin
        out_data_reg <= mem[rd_ptr_reg];
        last_reg     <= mem[rd_ptr_reg];
      end else if (underflow_event) begin
        out_data_reg <= bus.holdOnEmpty ? last_reg : '0;
      end
    end
  end

  // Sticky status flags. A new event in the same cycle as clearFlags keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow_reg <= 1'b1;
      end else if (bus.clearFlags) begin
        overflow_reg <= 1'b0;
      end
      if (underflow_event) begin
        underflow_reg <= 1'b1;
      end else if (bus.clearFlags) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign bus.outData   = out_data_reg;
  assign bus.outValid  = out_valid_reg;
  assign bus.level     = level_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_dac_sample_buffer.sv
// Testbench for dac_sample_buffer: directed scenarios, then random traffic checked against a queue model.
module tb_dac_sample_buffer;
  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int GW    = 2;

  logic clk;
  logic reset;

  dac_sample_buffer_if #(.DataWidth(DW), .Depth(DEPTH), .GainWidth(GW)) bus ();

  dac_sample_buffer #(.DataWidth(DW), .Depth(DEPTH), .GainWidth(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_out;
  logic [DW-1:0] m_last;
  bit            m_of;
  bit            m_uf;

  // Saturating gain computed with plain integer arithmetic
  function automatic logic [DW-1:0] sat(input logic [DW-1:0] d, input int g);
    int v;
    v = $signed(d);
    v = v * (1 << g);
    if (v > 2047)  v = 2047;
    if (v < -2048) v = -2048;
    return v[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("outData", 32'(bus.outData), 32'(m_out));
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_of));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
  endtask

  // One clock cycle: drive the pulses, advance the model, then check the outputs after the edge
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit clr);
    bus.inValid    = v;
    bus.inData     = d;
    bus.outReq     = r;
    bus.clearFlags = clr;
    if (clr) begin
      m_of = 0;
      m_uf = 0;
    end
    if (r) begin
      if (q.size() > 0) begin
        m_out  = q.pop_front();
        m_last = m_out;
      end else begin
        m_out = bus.holdOnEmpty ? m_last : '0;
        m_uf  = 1;
      end
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(sat(d, int'(bus.gainShift)));
      else m_of = 1;
    end
    @(posedge clk);
    #1;
    bus.inValid    = 0;
    bus.outReq     = 0;
    bus.clearFlags = 0;
    $display("t=%0t push=%0b in=%h gain=%0d req=%0b clr=%0b -> out=%h valid=%0b level=%0d of=%0b uf=%0b",
             $time, v, d, bus.gainShift, r, clr, bus.outData, bus.outValid, bus.level,
             bus.overflow, bus.underflow);
    chk("outValid", 32'(bus.outValid), 32'(r));
    check_model();
  endtask

  // Asynchronous reset pulse, with the outputs checked while reset is still asserted
  task automatic do_reset();
    bus.inValid    = 0;
    bus.outReq     = 0;
    bus.clearFlags = 0;
    reset = 1;
    #1;
    q.delete();
    m_out  = '0;
    m_last = '0;
    m_of   = 0;
    m_uf   = 0;
    chk("rst_outValid", 32'(bus.outValid), 32'd0);
    check_model();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    clk = 0;
    reset = 1;
    bus.inValid = 0;
    bus.inData = '0;
    bus.gainShift = '0;
    bus.holdOnEmpty = 1;
    bus.outReq = 0;
    bus.clearFlags = 0;
    q.delete();
    m_out = '0;
    m_last = '0;
    m_of = 0;
    m_uf = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Gain and saturation
    bus.gainShift = 2'd0; step(1, 12'h123, 0, 0); step(0, 0, 1, 0);
    chk("gain0", 32'(bus.outData), 32'h123);
    bus.gainShift = 2'd2; step(1, 12'h100, 0, 0); step(0, 0, 1, 0);
    chk("gain2", 32'(bus.outData), 32'h400);
    bus.gainShift = 2'd2; step(1, 12'h300, 0, 0); step(0, 0, 1, 0);
    chk("sat_pos", 32'(bus.outData), 32'h7FF);
    bus.gainShift = 2'd1; step(1, 12'h900, 0, 0); step(0, 0, 1, 0);
    chk("sat_neg", 32'(bus.outData), 32'h800);

    // Ordering, latency and level steps
    bus.gainShift = 2'd0;
    for (int i = 1; i <= 4; i++) step(1, 12'(i), 0, 0);
    chk("level_full", 32'(bus.level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 0);
      chk("order_data", 32'(bus.outData), 32'(i));
      chk("order_level", 32'(bus.level), 32'(4 - i));
    end
    step(0, 0, 0, 0);
    chk("valid_one_cycle", 32'(bus.outValid), 32'd0);

    // Overflow
    for (int i = 10; i <= 14; i++) step(1, 12'(i), 0, 0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd4);
    for (int i = 10; i <= 13; i++) begin
      step(0, 0, 1, 0);
      chk("ovf_data", 32'(bus.outData), 32'(i));
    end
    step(0, 0, 0, 1);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // Underflow policy
    step(1, 12'h055, 0, 0);
    step(0, 0, 1, 0);
    bus.holdOnEmpty = 1; step(0, 0, 1, 0);
    chk("uf_hold", 32'(bus.outData), 32'h055);
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    bus.holdOnEmpty = 0; step(0, 0, 1, 0);
    chk("uf_zero", 32'(bus.outData), 32'h000);
    step(0, 0, 0, 1);
    chk("uf_clear", 32'(bus.underflow), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) step(1, 12'(8'h21 + i), 0, 0);
    step(1, 12'h025, 1, 0);
    chk("full_both_data", 32'(bus.outData), 32'h021);
    chk("full_both_level", 32'(bus.level), 32'd4);
    chk("full_both_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("full_both_last", 32'(bus.outData), 32'h025);

    // Simultaneous push and pop while empty
    step(1, 12'h031, 1, 0);
    chk("empty_both_uf", 32'(bus.underflow), 32'd1);
    chk("empty_both_level", 32'(bus.level), 32'd1);
    step(0, 0, 1, 1);
    chk("empty_both_data", 32'(bus.outData), 32'h031);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) step(1, 12'(8'h40 + i), 0, 0);
    step(1, 12'h050, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_level", 32'(bus.level), 32'd3);
    do_reset();
    chk("rst_level", 32'(bus.level), 32'd0);
    bus.holdOnEmpty = 1;
    step(0, 0, 1, 0);
    chk("rst_hold_zero", 32'(bus.outData), 32'h000);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bus.gainShift   = 2'($urandom_range(0, 3));
      bus.holdOnEmpty = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
